// File: rtl/deb_sched.sv
`default_nettype none
// ============================================================================
// deb_sched : time-shared debounce controller, one stability counter
//             arbitrated round-robin among N synchronized inputs.
// Revision  : 1.0
// ============================================================================
module deb_sched #(
  parameter  int   N       = 4,
  parameter  int   CNT_W   = 8,
  parameter  logic OUT_RST = 1'b1,
  localparam int   SEL_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in,
  input  logic             en,
  output logic [N-1:0]     out,
  output logic [N-1:0]     rise,
  output logic [N-1:0]     fall,
  output logic             busy,
  output logic [SEL_W-1:0] sel
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [N-1:0]       s1_q, s_q;
  logic [N-1:0]       out_q, out_d;
  logic [N-1:0]       rise_q, rise_d;
  logic [N-1:0]       fall_q, fall_d;
  logic               busy_q, busy_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               val_q, val_d;
  logic [N-1:0]       mism;
  logic [SEL_W-1:0]   pick;
  logic [SEL_W-1:0]   sel_next;

  // First requesting channel at or after start, wrapping modulo N.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [N-1:0]     req,
                                               input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] res;
    logic [SEL_W:0]   sum;
    res = start;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, start} + (SEL_W+1)'(k);
      if (sum >= (SEL_W+1)'(N)) sum = sum - (SEL_W+1)'(N);
      if (req[sum[SEL_W-1:0]]) res = sum[SEL_W-1:0];
    end
    return res;
  endfunction

  assign mism     = s_q ^ out_q;
  assign pick     = rr_pick(mism, ptr_q);
  assign sel_next = (sel_q == SEL_W'(N - 1)) ? '0 : sel_q + SEL_W'(1);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    rise_d  = '0;
    fall_d  = '0;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    unique case (state_q)
      IDLE: begin
        if (|mism) begin
          sel_d   = pick;
          val_d   = s_q[pick];
          cnt_d   = '0;
          state_d = TRACK;
        end
      end
      TRACK: begin
        // A bounce back to the committed level abandons the attempt.
        if (s_q[sel_q] != val_q) begin
          ptr_d   = sel_next;
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          out_d[sel_q]  = val_q;
          rise_d[sel_q] = val_q;
          fall_d[sel_q] = ~val_q;
          ptr_d         = sel_next;
          state_d       = DONE;
        end else if (en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= {N{OUT_RST}};
      s_q     <= {N{OUT_RST}};
      out_q   <= {N{OUT_RST}};
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= in;
      s_q     <= s1_q;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;
  assign sel  = sel_q;

endmodule
`default_nettype wire
